// File: rtl/decoder_n_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a handshaked direct mode and an auto-scan mode.
// Define DECODER_N_SEQ_ACTIVE_LOW_OUT_EN to drive dout active-low (idle all ones, selected bit 0).
module decoder_n_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   dout,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [OUT_W-1:0]   dout_hot;
  logic [SEL_W-1:0]   next_idx;

  // Handshake: a select transfers on a rising clk edge where sel_valid & sel_ready;
  // sel_valid may be held, sel_ready never waits on sel_valid.
  assign sel_ready = (state == ST_IDLE) & en & ~mode & ~rst;
  assign next_idx  = cur_sel + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dout_hot <= '0;
      cur_sel  <= '0;
      wrap     <= 1'b0;
    end else if (!en) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dout_hot <= '0;
      cur_sel  <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mode) begin
            state    <= ST_SCAN;
            dout_hot <= ONE;
            cur_sel  <= '0;
            cnt      <= dwell;
          end else if (sel_valid) begin
            state    <= ST_DIRECT;
            dout_hot <= ONE << sel;
            cur_sel  <= sel;
            cnt      <= dwell;
          end else begin
            dout_hot <= '0;
            cur_sel  <= '0;
            cnt      <= '0;
          end
        end
        ST_DIRECT: begin
          if (cnt == '0) begin
            state    <= ST_IDLE;
            dout_hot <= '0;
            cur_sel  <= '0;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        ST_SCAN: begin
          // An index in progress always runs to completion before mode is honoured.
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (!mode) begin
            state    <= ST_IDLE;
            dout_hot <= '0;
            cur_sel  <= '0;
          end else begin
            dout_hot <= ONE << next_idx;
            cur_sel  <= next_idx;
            cnt      <= dwell;
            wrap     <= (next_idx == '0);
          end
        end
        default: begin
          state    <= ST_IDLE;
          dout_hot <= '0;
          cur_sel  <= '0;
          cnt      <= '0;
        end
      endcase
    end
  end

`ifdef DECODER_N_SEQ_ACTIVE_LOW_OUT_EN
  assign dout = ~dout_hot;
`else
  assign dout = dout_hot;
`endif

endmodule
